// File: rtl/roi_pkg.sv
// roi_pkg: shared types and corner normalization
// for the ROI crop sequencer.
package roi_pkg;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } roi_xy_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } roi_state_e;

  typedef struct packed {
    logic [15:0] x_min;
    logic [15:0] x_max;
    logic [15:0] y_min;
    logic [15:0] y_max;
    logic        err;
  } roi_box_t;

  function automatic roi_box_t roi_norm(
    roi_xy_t     xy0,
    roi_xy_t     xy1,
    logic [31:0] w,
    logic [31:0] h
  );
    roi_box_t b;
    b.x_min = (xy0.x < xy1.x) ? xy0.x : xy1.x;
    b.x_max = (xy0.x < xy1.x) ? xy1.x : xy0.x;
    b.y_min = (xy0.y < xy1.y) ? xy0.y : xy1.y;
    b.y_max = (xy0.y < xy1.y) ? xy1.y : xy0.y;
    b.err   = ({16'd0, b.x_max} >= w) ||
              ({16'd0, b.y_max} >= h);
    return b;
  endfunction

endpackage

// File: rtl/roi_ctrl_if.sv
// roi_ctrl_if: pixel stream in/out bundle
// around the ROI crop sequencer.
interface roi_ctrl_if #(
  parameter int unsigned BIT_D = 8
);
  logic [BIT_D-1:0] s_data;
  logic             s_valid;
  logic             s_sof;
  logic             s_ready;
  logic [BIT_D-1:0] m_data;
  logic             m_valid;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;
  logic             m_ready;

  modport master (
    output s_data, s_valid, s_sof, m_ready,
    input  s_ready, m_data, m_valid,
    input  m_sof, m_eol, m_eof
  );

  modport slave (
    input  s_data, s_valid, s_sof, m_ready,
    output s_ready, m_data, m_valid,
    output m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/roi_pos_cnt.sv
// roi_pos_cnt: raster x/y position counter.
// Outputs show the position of the current pixel.
module roi_pos_cnt #(
  parameter int unsigned W  = 800,
  parameter int unsigned H  = 600,
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_col_o,
  output logic          last_pix_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // clear takes effect on the same beat so a
  // frame-start pixel is itself at (0,0)
  always_comb begin
    x_o        = clr_i ? '0 : x_q;
    y_o        = clr_i ? '0 : y_q;
    last_col_o = (x_o == XW'(W - 1));
    last_pix_o = last_col_o &&
                 (y_o == YW'(H - 1));
    x_d        = x_o;
    y_d        = y_o;
    if (inc_i) begin
      if (last_col_o) begin
        x_d = '0;
        y_d = last_pix_o ? '0 : y_o + 1'b1;
      end else begin
        x_d = x_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/roi_ctrl.sv
// roi_ctrl: crops a raster pixel stream to a
// rectangle latched from the APB corner words.
module roi_ctrl
  import roi_pkg::*;
#(
  parameter int unsigned WIDTH  = 800,
  parameter int unsigned HEIGHT = 600,
  parameter int unsigned BIT_D  = 8,
  parameter int unsigned BIT_C  = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [BIT_C-1:0] xy_0_i,
  input  logic [BIT_C-1:0] xy_1_i,
  input  logic             cfg_upd_i,
  input  logic [BIT_D-1:0] s_data_i,
  input  logic             s_valid_i,
  input  logic             s_sof_i,
  output logic             s_ready_o,
  output logic [BIT_D-1:0] m_data_o,
  output logic             m_valid_o,
  output logic             m_sof_o,
  output logic             m_eol_o,
  output logic             m_eof_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             cfg_err_o
);

  localparam int unsigned XW =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW =
    (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  roi_state_e         state_q, state_d;
  logic [2*BIT_C-1:0] pend_q, pend_d;
  roi_box_t           box_q, box_d;
  logic [BIT_D-1:0]   data_q, data_d;
  logic               vld_q, vld_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic               done_q, done_d;

  logic               acc;
  logic               sof_acc;
  logic               cnt_inc;
  logic               frame_end;
  logic               last_col;
  logic               last_pix;
  logic               in_roi;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [15:0]        x16;
  logic [15:0]        y16;

  assign s_ready_o = arst_i & (~vld_q | m_ready_i);
  assign acc       = s_valid_i & s_ready_o;
  assign sof_acc   = acc & s_sof_i;
  // only pixels belonging to a frame move the raster
  assign cnt_inc   = acc &
                     ((state_q == ACTIVE) | s_sof_i);
  assign frame_end = cnt_inc & last_col & last_pix;

  roi_pos_cnt #(
    .W  (WIDTH),
    .H  (HEIGHT),
    .XW (XW),
    .YW (YW)
  ) u_pos (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .clr_i      (sof_acc),
    .inc_i      (cnt_inc),
    .x_o        (x),
    .y_o        (y),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  assign x16 = 16'(x);
  assign y16 = 16'(y);

  assign pend_d = cfg_upd_i ? {xy_1_i, xy_0_i}
                            : pend_q;

  // a same-cycle update overrides the pending copy
  always_comb begin
    box_d = box_q;
    if (sof_acc) begin
      if (cfg_upd_i) begin
        box_d = roi_norm(xy_0_i, xy_1_i,
                         32'(WIDTH), 32'(HEIGHT));
      end else begin
        box_d = roi_norm(pend_q[BIT_C-1:0],
                         pend_q[2*BIT_C-1:BIT_C],
                         32'(WIDTH), 32'(HEIGHT));
      end
    end
  end

  assign in_roi = ~box_d.err &
                  (x16 >= box_d.x_min) &
                  (x16 <= box_d.x_max) &
                  (y16 >= box_d.y_min) &
                  (y16 <= box_d.y_max);

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sof_d  = sof_q;
    eol_d  = eol_q;
    eof_d  = eof_q;
    if (cnt_inc && in_roi) begin
      vld_d  = 1'b1;
      data_d = s_data_i;
      sof_d  = (x16 == box_d.x_min) &&
               (y16 == box_d.y_min);
      eol_d  = (x16 == box_d.x_max);
      eof_d  = (x16 == box_d.x_max) &&
               (y16 == box_d.y_max);
    end else if (m_ready_i) begin
      vld_d = 1'b0;
      sof_d = 1'b0;
      eol_d = 1'b0;
      eof_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = frame_end;
    unique case (state_q)
      IDLE: begin
        if (sof_acc && !frame_end) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      box_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      box_q   <= box_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  assign m_data_o     = data_q;
  assign m_valid_o    = vld_q;
  assign m_sof_o      = sof_q;
  assign m_eol_o      = eol_q;
  assign m_eof_o      = eof_q;
  assign busy_o       = (state_q == ACTIVE);
  assign frame_done_o = done_q;
  assign cfg_err_o    = box_q.err;

endmodule

// File: tb/tb_roi_ctrl.sv
// tb_roi_ctrl: directed and randomized frames
// on an 8x6 raster against a box-level model.
module tb_roi_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk  = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] xy0  = '0;
  logic [31:0] xy1  = '0;
  logic        cfg_upd = 1'b0;
  logic        busy;
  logic        fdone;
  logic        cerr;

  roi_ctrl_if #(.BIT_D(8)) bus ();

  roi_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .BIT_D  (8),
    .BIT_C  (32)
  ) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .xy_0_i       (xy0),
    .xy_1_i       (xy1),
    .cfg_upd_i    (cfg_upd),
    .s_data_i     (bus.s_data),
    .s_valid_i    (bus.s_valid),
    .s_sof_i      (bus.s_sof),
    .s_ready_o    (bus.s_ready),
    .m_data_o     (bus.m_data),
    .m_valid_o    (bus.m_valid),
    .m_sof_o      (bus.m_sof),
    .m_eol_o      (bus.m_eol),
    .m_eof_o      (bus.m_eof),
    .m_ready_i    (bus.m_ready),
    .busy_o       (busy),
    .frame_done_o (fdone),
    .cfg_err_o    (cerr)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  int          gapmax = 0;
  bit          rnd_rdy = 1'b0;
  logic [10:0] expq[$];
  logic [10:0] obs[$];

  task automatic chk(string tag,
                     int unsigned o,
                     int unsigned e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, o, e);
    end
  endtask

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mx(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit model_err(logic [31:0] a,
                                   logic [31:0] b);
    return mx(int'(a[15:0]), int'(b[15:0])) >= W ||
           mx(int'(a[31:16]), int'(b[31:16])) >= H;
  endfunction

  // Expected beats for rows ylo..yhi cropped to box a/b
  function automatic void expect_rows(logic [31:0] a,
                                      logic [31:0] b,
                                      int ylo, int yhi);
    int xl, xh, yl, yh;
    xl = mn(int'(a[15:0]), int'(b[15:0]));
    xh = mx(int'(a[15:0]), int'(b[15:0]));
    yl = mn(int'(a[31:16]), int'(b[31:16]));
    yh = mx(int'(a[31:16]), int'(b[31:16]));
    if (model_err(a, b)) return;
    for (int y = ylo; y <= yhi; y++)
      for (int x = 0; x < W; x++)
        if (x >= xl && x <= xh && y >= yl && y <= yh)
          expq.push_back({8'(y * W + x),
                          (x == xl && y == yl),
                          (x == xh),
                          (x == xh && y == yh)});
  endfunction

  always @(negedge clk) begin
    logic [10:0] beat;
    if (fdone) n_done++;
    if (arst && bus.m_valid && bus.m_ready) begin
      beat = {bus.m_data, bus.m_sof,
              bus.m_eol, bus.m_eof};
      if (expq.size() == 0)
        chk("extra_beat", beat, 32'hFFFF_FFFF);
      else
        chk("beat", beat, expq.pop_front());
      obs.push_back(beat);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy)
      bus.m_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic cfg(logic [31:0] a, logic [31:0] b);
    xy0     = a;
    xy1     = b;
    cfg_upd = 1'b1;
    @(posedge clk);
    #1;
    cfg_upd = 1'b0;
  endtask

  task automatic send(logic [7:0] d, bit sof);
    int g = 0;
    bus.s_data  = d;
    bus.s_sof   = sof;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (g >= 100) chk("send_timeout", g, 0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rows(int ylo, int yhi, bit sof0);
    for (int y = ylo; y <= yhi; y++)
      for (int x = 0; x < W; x++)
        send(8'(y * W + x),
             sof0 && y == ylo && x == 0);
  endtask

  task automatic drain();
    int g = 0;
    while ((expq.size() != 0 || bus.m_valid)
           && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic check_basic(string tag);
    logic [10:0] t;
    chk({tag, "_n"}, obs.size(), 6);
    t = obs[0];
    chk({tag, "_first"}, t[10:3], 10);
    t = obs[5];
    chk({tag, "_last"}, t, {8'd20, 3'b011});
  endtask

  initial begin
    logic [31:0] a, b;
    logic [10:0] t;
    int          nd0;

    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b1;

    // reset with traffic present
    #1 arst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b1;
    bus.s_data  = 8'h5A;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cerr, 0);
    chk("rst_done", fdone, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    arst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_beats", obs.size(), 0);

    // basic crop
    a = 32'h0001_0002;
    b = 32'h0002_0004;
    cfg(a, b);
    obs.delete();
    expect_rows(a, b, 0, H - 1);
    nd0 = n_done;
    send_rows(0, H - 1, 1'b1);
    drain();
    check_basic("basic");
    chk("basic_done", n_done - nd0, 1);
    chk("basic_busy", busy, 0);
    chk("basic_err", cerr, 0);

    // swapped corners
    cfg(b, a);
    obs.delete();
    expect_rows(b, a, 0, H - 1);
    send_rows(0, H - 1, 1'b1);
    drain();
    check_basic("swap");

    // invalid box
    cfg(a, 32'h0002_0008);
    obs.delete();
    nd0 = n_done;
    send_rows(0, 0, 1'b1);
    chk("inv_err", cerr, 1);
    chk("inv_busy", busy, 1);
    send_rows(1, H - 1, 1'b0);
    drain();
    chk("inv_beats", obs.size(), 0);
    chk("inv_done", n_done - nd0, 1);
    cfg(a, b);
    obs.delete();
    expect_rows(a, b, 0, H - 1);
    send_rows(0, H - 1, 1'b1);
    drain();
    chk("inv_clear", cerr, 0);
    check_basic("inv_recover");

    // backpressure on data 11
    obs.delete();
    expect_rows(a, b, 0, H - 1);
    fork
      send_rows(0, H - 1, 1'b1);
      begin
        int g = 0;
        while (!(bus.m_valid && bus.m_data == 8'd11)
               && g < 500) begin
          @(posedge clk);
          #1;
          g++;
        end
        chk("bp_seen", g < 500, 1);
        bus.m_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold", bus.m_data, 11);
          chk("bp_s_ready", bus.s_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    drain();
    check_basic("bp");

    // mid-frame update then resync at y=3
    obs.delete();
    nd0 = n_done;
    expect_rows(a, b, 0, 2);
    expect_rows(32'h0, 32'h0, 0, H - 1);
    send_rows(0, 0, 1'b1);
    cfg(32'h0, 32'h0);
    send_rows(1, 2, 1'b0);
    send_rows(0, H - 1, 1'b1);
    drain();
    chk("rs_n", obs.size(), 7);
    t = obs[2];
    chk("rs_old", t[10:3], 12);
    t = obs[6];
    chk("rs_single", t, {8'd0, 3'b111});
    chk("rs_done", n_done - nd0, 1);

    // random boxes, gaps and output stalls
    rnd_rdy = 1'b1;
    gapmax  = 2;
    for (int k = 0; k < 8; k++) begin
      a = {16'($urandom_range(0, 7)),
           16'($urandom_range(0, 9))};
      b = {16'($urandom_range(0, 7)),
           16'($urandom_range(0, 9))};
      cfg(a, b);
      send(8'hAA, 1'b0);
      send(8'h55, 1'b0);
      nd0 = n_done;
      expect_rows(a, b, 0, H - 1);
      send_rows(0, H - 1, 1'b1);
      drain();
      chk("rnd_err", cerr, model_err(a, b));
      chk("rnd_done", n_done - nd0, 1);
    end
    rnd_rdy = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
